// File: rtl/fetch_pc_gen.sv
// Instruction-fetch front end: owns the fetch PC, issues one aligned word request at a time
// and buffers the returned word for decode; redirects flush the buffer and kill any in-flight fetch.
module fetch_pc_gen #(
    parameter int unsigned     ALEN     = 32,
    parameter logic [ALEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [ALEN-1:0] redirect_target,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [ALEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [31:0]     mem_resp_data,
    input  logic            mem_resp_error,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [31:0]     fetch_instr,
    output logic [ALEN-1:0] fetch_addr,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        KILL
    } state_t;

    localparam logic [ALEN-1:0] WORD_MASK  = ~ALEN'(3);
    localparam logic [ALEN-1:0] HALF_MASK  = ~ALEN'(1);
    localparam logic [ALEN-1:0] WORD_BYTES = ALEN'(4);

    state_t          state;
    logic [ALEN-1:0] pc;
    logic [ALEN-1:0] req_pc;
    logic            req_ok;

    // A request may only issue when its response is guaranteed an empty buffer.
    assign req_ok        = (state == IDLE) && !redirect_valid && (!fetch_valid || fetch_ready);
    assign mem_req_valid = req_ok && !rst;
    assign mem_req_addr  = pc & WORD_MASK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC & HALF_MASK;
            req_pc      <= '0;
            fetch_valid <= 1'b0;
            fetch_instr <= '0;
            fetch_addr  <= '0;
            fetch_fault <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults first, later assignments in this block override them,
            // which is how refill beats consume and redirect beats everything.
            if (fetch_valid && fetch_ready) begin
                fetch_valid <= 1'b0;
            end

            if (redirect_valid) begin
                pc          <= redirect_target & HALF_MASK;
                fetch_valid <= 1'b0;
                case (state)
                    WAIT:    state <= mem_resp_valid ? IDLE : KILL;
                    KILL:    if (mem_resp_valid) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (req_ok && mem_req_ready) begin
                            state  <= WAIT;
                            req_pc <= pc;
                        end
                    end
                    WAIT: begin
                        if (mem_resp_valid) begin
                            fetch_valid <= 1'b1;
                            fetch_instr <= mem_resp_data;
                            fetch_addr  <= req_pc;
                            fetch_fault <= mem_resp_error;
                            pc          <= (req_pc & WORD_MASK) + WORD_BYTES;
                            state       <= IDLE;
                        end
                    end
                    KILL: begin
                        if (mem_resp_valid) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: bench-side memory with variable latency plus a transaction-level
// model of the fetch stream (next PC, one in-flight fetch, queue of words owed to decode).
module tb_fetch_pc_gen;

    localparam int          ALEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        fault;
    } item_t;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_error;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_addr;
    logic        fetch_fault;

    fetch_pc_gen #(.ALEN(ALEN), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_error(mem_resp_error),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_instr(fetch_instr),
        .fetch_addr(fetch_addr), .fetch_fault(fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Bench memory: at most one outstanding access, answered lat_min..lat_max cycles later.
    logic        pend;
    int          pend_due;
    logic [31:0] pend_addr;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;
    logic [31:0] fault_addr = 32'hFFFF_FFFF;

    // Reference model of the fetch stream.
    logic [31:0] next_pc;
    logic        inflight_live;
    logic [31:0] inflight_pc;
    item_t       exp_q[$];

    logic [31:0] acc_log[$];
    int          acc_cyc_log[$];
    item_t       cons_log[$];
    int          first_valid_cyc;
    logic        last_resp;
    logic        last_valid;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C ^ (a << 3);
    endfunction

    function automatic logic fault_of(input logic [31:0] a);
        return (a & ~32'h3) == fault_addr;
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        logic [31:0] v;
        v = 'x;
        if (i < acc_log.size()) v = acc_log[i];
        return v;
    endfunction

    function automatic item_t cons_at(input int i);
        item_t v;
        v = 'x;
        if (i < cons_log.size()) v = cons_log[i];
        return v;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        next_pc       = RESET_PC;
        pend          = 1'b0;
        inflight_live = 1'b0;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        acc_cyc_log.delete();
        cons_log.delete();
        first_valid_cyc = -1;
    endtask

    // One clock cycle: caller sets the control inputs; the memory side, scoreboard and logs live here.
    task automatic cycle();
        logic        acc, cons, resp, exp_req;
        logic [31:0] acc_addr;
        item_t       got;
        if (pend && cyc == pend_due) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_data(pend_addr);
            mem_resp_error = fault_of(pend_addr);
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            mem_resp_error = 1'($urandom_range(0, 1));
        end
        #1;
        acc        = mem_req_valid && mem_req_ready;
        cons       = fetch_valid && fetch_ready;
        resp       = mem_resp_valid;
        acc_addr   = mem_req_addr;
        last_resp  = resp;
        last_valid = fetch_valid;
        if (fetch_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        exp_req = !pend && !redirect_valid && (exp_q.size() == 0 || fetch_ready);

        checks++;
        if (fetch_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL fetch_valid cyc=%0d got=%b want=%b", cyc, fetch_valid, exp_q.size() != 0);
        end
        checks++;
        if (mem_req_valid !== exp_req) begin
            errors++;
            $display("FAIL mem_req_valid cyc=%0d got=%b want=%b", cyc, mem_req_valid, exp_req);
        end
        if (exp_req) begin
            checks++;
            if (mem_req_addr !== (next_pc & ~32'h3)) begin
                errors++;
                $display("FAIL mem_req_addr cyc=%0d got=%h want=%h", cyc, mem_req_addr, next_pc & ~32'h3);
            end
        end
        if (cons && exp_q.size() != 0) begin
            got = '{addr: fetch_addr, instr: fetch_instr, fault: fetch_fault};
            checks++;
            if (got !== exp_q[0]) begin
                errors++;
                $display("FAIL fetch_item cyc=%0d got addr=%h instr=%h fault=%b want addr=%h instr=%h fault=%b",
                         cyc, got.addr, got.instr, got.fault, exp_q[0].addr, exp_q[0].instr, exp_q[0].fault);
            end
            cons_log.push_back(got);
        end

        @(posedge clk);
        if (cons && exp_q.size() != 0) void'(exp_q.pop_front());
        if (redirect_valid) begin
            exp_q.delete();
            inflight_live = 1'b0;
            next_pc       = redirect_target & ~32'h1;
        end
        if (resp) begin
            pend = 1'b0;
            if (inflight_live)
                exp_q.push_back('{addr: inflight_pc, instr: mem_data(inflight_pc & ~32'h3),
                                  fault: fault_of(inflight_pc)});
            inflight_live = 1'b0;
        end
        if (acc) begin
            pend          = 1'b1;
            pend_due      = cyc + int'($urandom_range(lat_max, lat_min));
            pend_addr     = acc_addr;
            inflight_live = 1'b1;
            inflight_pc   = next_pc;
            next_pc       = (next_pc & ~32'h3) + 32'd4;
            acc_log.push_back(acc_addr);
            acc_cyc_log.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid  = 1'b1;
        redirect_target = target;
        cycle();
        redirect_valid  = 1'b0;
    endtask

    task automatic wait_accept(input string what);
        int   n0;
        logic seen;
        n0   = acc_log.size();
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle();
            seen = acc_log.size() > n0;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout got no accepted request want one within 30 cycles", what);
        end
    endtask

    task automatic wait_valid(input string what);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cycle();
            seen = last_valid;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout got no fetch_valid want one within 30 cycles", what);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_target = '0;
        mem_req_ready = 1'b1; fetch_ready = 1'b1;
        mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_error = 1'b0;
        model_reset();
        clear_logs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({fetch_valid, fetch_fault, mem_req_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got valid=%b fault=%b req=%b want 0 0 0", fetch_valid, fetch_fault, mem_req_valid);
        end
        checks++;
        if (fetch_instr !== 32'h0 || fetch_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got instr=%h addr=%h want 0 0", fetch_instr, fetch_addr);
        end
        checks++;
        if (mem_req_addr !== (RESET_PC & ~32'h3)) begin
            errors++;
            $display("FAIL reset_pc got %h want %h", mem_req_addr, RESET_PC & ~32'h3);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        clear_logs();
        lat_min = 1; lat_max = 1;
        run(8);
        checks++;
        if (acc_at(0) !== 32'h0 || acc_at(1) !== 32'h4 || acc_at(2) !== 32'h8) begin
            errors++;
            $display("FAIL seq_req got %h %h %h want 0 4 8", acc_at(0), acc_at(1), acc_at(2));
        end
        checks++;
        if (cons_at(0).addr !== 32'h0 || cons_at(1).addr !== 32'h4 || cons_at(2).addr !== 32'h8) begin
            errors++;
            $display("FAIL seq_fetch_addr got %h %h %h want 0 4 8", cons_at(0).addr, cons_at(1).addr, cons_at(2).addr);
        end
        checks++;
        if (acc_cyc_log.size() == 0 || first_valid_cyc - acc_cyc_log[0] != 2) begin
            errors++;
            $display("FAIL seq_latency got first valid %0d cycles after accept want 2",
                     acc_cyc_log.size() == 0 ? -1 : first_valid_cyc - acc_cyc_log[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        fetch_ready = 1'b0;
        wait_valid("bp_fill");
        held = fetch_instr;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (fetch_instr !== held || mem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold got instr=%h req=%b want instr=%h req=0", fetch_instr, mem_req_valid, held);
            end
        end
        fetch_ready = 1'b1;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got mem_req_valid=%b want 1", mem_req_valid);
        end
        run(4);
    endtask

    task automatic test_redirect_wait();
        lat_min = 3; lat_max = 3;
        redirect_to(32'h8);
        clear_logs();
        wait_accept("rw_issue");
        redirect_to(32'h100);
        run(12);
        checks++;
        if (acc_at(0) !== 32'h8 || acc_at(1) !== 32'h100) begin
            errors++;
            $display("FAIL rw_req got %h %h want 8 100", acc_at(0), acc_at(1));
        end
        checks++;
        if (cons_at(0).addr !== 32'h100 || cons_at(0).instr !== mem_data(32'h100)) begin
            errors++;
            $display("FAIL rw_fetch got addr=%h instr=%h want addr=100 instr=%h",
                     cons_at(0).addr, cons_at(0).instr, mem_data(32'h100));
        end
    endtask

    task automatic test_redirect_coincident();
        lat_min = 2; lat_max = 2;
        redirect_to(32'h10);
        wait_accept("rc_issue");
        for (int i = 0; i < 10 && !(pend && cyc == pend_due); i++) cycle();
        redirect_valid  = 1'b1;
        redirect_target = 32'h202;
        cycle();
        redirect_valid  = 1'b0;
        checks++;
        if (last_resp !== 1'b1) begin
            errors++;
            $display("FAIL rc_coincide got mem_resp_valid=%b with redirect want 1", last_resp);
        end
        clear_logs();
        run(10);
        checks++;
        if (acc_at(0) !== 32'h200 || acc_at(1) !== 32'h204) begin
            errors++;
            $display("FAIL rc_req got %h %h want 200 204", acc_at(0), acc_at(1));
        end
        checks++;
        if (cons_at(0).addr !== 32'h202 || cons_at(0).instr !== mem_data(32'h200) || cons_at(1).addr !== 32'h204) begin
            errors++;
            $display("FAIL rc_fetch got %h/%h then %h want 202/%h then 204",
                     cons_at(0).addr, cons_at(0).instr, cons_at(1).addr, mem_data(32'h200));
        end
    endtask

    task automatic test_fault();
        lat_min = 1; lat_max = 1;
        fault_addr = 32'h40;
        redirect_to(32'h40);
        clear_logs();
        run(10);
        checks++;
        if (cons_at(0).addr !== 32'h40 || cons_at(0).fault !== 1'b1) begin
            errors++;
            $display("FAIL fault_set got addr=%h fault=%b want 40 1", cons_at(0).addr, cons_at(0).fault);
        end
        checks++;
        if (acc_at(1) !== 32'h44 || cons_at(1).addr !== 32'h44 || cons_at(1).fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_next got req=%h addr=%h fault=%b want 44 44 0", acc_at(1), cons_at(1).addr, cons_at(1).fault);
        end
        fault_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_back_to_back();
        redirect_to(32'h300);
        redirect_to(32'h400);
        clear_logs();
        run(6);
        checks++;
        if (acc_at(0) !== 32'h400 || cons_at(0).addr !== 32'h400) begin
            errors++;
            $display("FAIL b2b got req=%h fetch=%h want 400 400", acc_at(0), cons_at(0).addr);
        end
    endtask

    task automatic test_wrap();
        lat_min = 1; lat_max = 1;
        redirect_to(32'hFFFF_FFFC);
        clear_logs();
        run(8);
        checks++;
        if (acc_at(0) !== 32'hFFFF_FFFC || acc_at(1) !== 32'h0) begin
            errors++;
            $display("FAIL wrap_req got %h %h want fffffffc 0", acc_at(0), acc_at(1));
        end
        checks++;
        if (cons_at(0).addr !== 32'hFFFF_FFFC || cons_at(1).addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_fetch got %h %h want fffffffc 0", cons_at(0).addr, cons_at(1).addr);
        end
    endtask

    task automatic test_async_reset();
        // Full buffer with an offered but unaccepted request, then reset between edges.
        lat_min = 1; lat_max = 1;
        fetch_ready = 1'b0;
        wait_valid("ar_fill");
        fetch_ready   = 1'b1;
        mem_req_ready = 1'b0;
        #2;
        checks++;
        if (fetch_valid !== 1'b1 || mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre got valid=%b req=%b want 1 1", fetch_valid, mem_req_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (fetch_valid !== 1'b0 || mem_req_valid !== 1'b0 || fetch_instr !== 32'h0 || fetch_addr !== 32'h0) begin
            errors++;
            $display("FAIL ar_drop got valid=%b req=%b instr=%h addr=%h want 0 0 0 0",
                     fetch_valid, mem_req_valid, fetch_instr, fetch_addr);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        mem_req_ready = 1'b1;

        // Reset mid-WAIT, then the stale response shows up while the new request is held off.
        lat_min = 5; lat_max = 5;
        clear_logs();
        wait_accept("ar_issue");
        checks++;
        if (acc_at(0) !== RESET_PC) begin
            errors++;
            $display("FAIL ar_first_req got %h want %h", acc_at(0), RESET_PC);
        end
        cycle();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (fetch_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_wait_drop got valid=%b req=%b want 0 0", fetch_valid, mem_req_valid);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        mem_resp_error = 1'b1;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== (RESET_PC & ~32'h3)) begin
            errors++;
            $display("FAIL ar_restart got req=%b addr=%h want 1 %h", mem_req_valid, mem_req_addr, RESET_PC & ~32'h3);
        end
        @(posedge clk);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_stale got fetch_valid=%b want 0", fetch_valid);
        end
        mem_req_ready = 1'b1;
        lat_min = 1; lat_max = 1;
        clear_logs();
        run(6);
        checks++;
        if (acc_at(0) !== RESET_PC || cons_at(0).addr !== RESET_PC || cons_at(0).instr !== mem_data(RESET_PC)) begin
            errors++;
            $display("FAIL ar_after got req=%h addr=%h instr=%h want %h %h %h",
                     acc_at(0), cons_at(0).addr, cons_at(0).instr, RESET_PC, RESET_PC, mem_data(RESET_PC));
        end
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 3;
        fault_addr = 32'h48;
        clear_logs();
        for (int i = 0; i < 2000; i++) begin
            mem_req_ready  = $urandom_range(0, 3) != 0;
            fetch_ready    = $urandom_range(0, 9) < 7;
            redirect_valid = $urandom_range(0, 11) == 0;
            case ($urandom_range(0, 3))
                0:       redirect_target = 32'($urandom_range(0, 511));
                1:       redirect_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                2:       redirect_target = 32'h40 + 32'($urandom_range(0, 15));
                default: redirect_target = $urandom;
            endcase
            cycle();
        end
        redirect_valid = 1'b0;
        fetch_ready    = 1'b1;
        mem_req_ready  = 1'b1;
        run(10);
        checks++;
        if (cons_log.size() < 100) begin
            errors++;
            $display("FAIL rand_progress got %0d words delivered want at least 100", cons_log.size());
        end
        fault_addr = 32'hFFFF_FFFF;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_coincident();
        test_fault();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
